crossing_sequencer: RTL

CROSSING_SEQUENCER -- requirements
Module: crossing_sequencer

---
 rtl/crossing_pkg.sv | 55 +++++
 rtl/crossing_sequencer_occupancy_counter.sv | 26 ++
 rtl/crossing_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/crossing_pkg.sv
// Shared definitions for the level-crossing sequencer: state encoding,
// default timing constants, track count and small combinational helpers.
package crossing_pkg;

  localparam int NUM_TRACKS         = 2;
  localparam int CNT_W              = 2;
  localparam int TIMER_W            = 16;

  localparam int DEF_WARN_CYCLES    = 8;
  localparam int DEF_CLEAR_CYCLES   = 4;
  localparam int DEF_MOTION_TIMEOUT = 16;
  localparam int DEF_FLASH_DIV      = 2;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WARN     = 3'd1,
    ST_LOWERING = 3'd2,
    ST_CLOSED   = 3'd3,
    ST_HOLD     = 3'd4,
    ST_RAISING  = 3'd5,
    ST_FAULT    = 3'd6
  } crossing_state_e;

  // Gate is commanded down in every state that protects the road crossing.
  function automatic logic gate_down_state(input crossing_state_e s);
    return (s == ST_LOWERING) || (s == ST_CLOSED) ||
           (s == ST_HOLD)     || (s == ST_FAULT);
  endfunction

  // One step of a saturating up/down occupancy count; simultaneous
  // entry and exit on the same track cancel out.
  function automatic logic [CNT_W-1:0] occ_next(input logic [CNT_W-1:0] cnt,
                                                input logic             inc,
                                                input logic             dec);
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    case ({inc, dec})
      2'b10: begin
        if (cnt == CNT_MAX) nxt = cnt;
        else                nxt = cnt + CNT_ONE;
      end
      2'b01: begin
        if (cnt == CNT_ZERO) nxt = cnt;
        else                 nxt = cnt - CNT_ONE;
      end
      default: nxt = cnt;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/crossing_sequencer_occupancy_counter.sv
// Per-track train occupancy counter: counts trains between the approach
// detector and the island exit detector, saturating at both ends.
module occupancy_counter
  import crossing_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Saturating count register, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= CNT_ZERO;
    end else begin
      r_count <= occ_next(r_count, i_inc, i_dec);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/crossing_sequencer.sv
// Level-crossing sequencer: warns road traffic, lowers the gate, clears the
// rail signal once the gate is down, and raises the gate after the island
// has been empty for a hold time.
// Optional feature: define CROSSING_MOTION_TIMEOUT_EN to enable the gate
// travel watchdog that latches FAULT; otherwise fault is tied to 0.
module crossing_sequencer
  import crossing_pkg::*;
#(
  parameter int WARN_CYCLES    = DEF_WARN_CYCLES,
  parameter int CLEAR_CYCLES   = DEF_CLEAR_CYCLES,
  parameter int MOTION_TIMEOUT = DEF_MOTION_TIMEOUT,
  parameter int FLASH_DIV      = DEF_FLASH_DIV
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_TRACKS-1:0] approach,
  input  logic [NUM_TRACKS-1:0] exit,
  input  logic                  gate_down_lim,
  input  logic                  gate_up_lim,
  output logic                  gate_cmd,
  output logic                  lamp,
  output logic                  train_ok,
  output logic                  fault
);

  localparam logic [TIMER_W-1:0] TIMER_ZERO  = {TIMER_W{1'b0}};
  localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] TIMER_MAX   = {TIMER_W{1'b1}};
  localparam logic [TIMER_W-1:0] WARN_LAST   = TIMER_W'(WARN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] CLEAR_LAST  = TIMER_W'(CLEAR_CYCLES - 1);
  localparam logic [TIMER_W-1:0] MOTION_LAST = TIMER_W'(MOTION_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] FLASH_LAST  = TIMER_W'(FLASH_DIV - 1);

`ifdef CROSSING_MOTION_TIMEOUT_EN
  localparam logic TIMEOUT_EN = 1'b1;
`else
  localparam logic TIMEOUT_EN = 1'b0;
`endif

  crossing_state_e r_state;
  crossing_state_e w_next_state;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] r_flash_cnt;
  logic r_lamp;
  logic r_gate_cmd;
  logic r_closed;
  logic r_fault;

  logic [NUM_TRACKS-1:0][CNT_W-1:0] w_count;
  logic [NUM_TRACKS-1:0] w_track_busy;
  logic w_occupied;
  logic w_any_approach;
  logic w_motion_expired;

  // One occupancy counter per track.
  for (genvar g = 0; g < NUM_TRACKS; g++) begin : g_track
    occupancy_counter u_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (approach[g]),
      .i_dec   (exit[g]),
      .o_count (w_count[g])
    );
    assign w_track_busy[g] = |w_count[g];
  end

  // Occupancy is judged from the registered counts only, never the pulses.
  assign w_occupied       = |w_track_busy;
  assign w_any_approach   = |approach;
  assign w_motion_expired = TIMEOUT_EN & (r_timer == MOTION_LAST);

  // Next-state decision for the crossing sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_approach) w_next_state = ST_WARN;
        else                w_next_state = ST_IDLE;
      end
      ST_WARN: begin
        if (r_timer == WARN_LAST) w_next_state = ST_LOWERING;
        else                      w_next_state = ST_WARN;
      end
      ST_LOWERING: begin
        if (gate_down_lim)         w_next_state = ST_CLOSED;
        else if (w_motion_expired) w_next_state = ST_FAULT;
        else                       w_next_state = ST_LOWERING;
      end
      ST_CLOSED: begin
        if (!w_occupied) w_next_state = ST_HOLD;
        else             w_next_state = ST_CLOSED;
      end
      ST_HOLD: begin
        // A returning train wins over an expiring hold timer.
        if (w_occupied)                w_next_state = ST_CLOSED;
        else if (r_timer == CLEAR_LAST) w_next_state = ST_RAISING;
        else                           w_next_state = ST_HOLD;
      end
      ST_RAISING: begin
        // A new train while raising re-lowers at once; the road was warned.
        if (w_any_approach)        w_next_state = ST_LOWERING;
        else if (gate_up_lim)      w_next_state = ST_IDLE;
        else if (w_motion_expired) w_next_state = ST_FAULT;
        else                       w_next_state = ST_RAISING;
      end
      ST_FAULT: begin
        w_next_state = ST_FAULT;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State, shared timer, lamp divider and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_timer     <= TIMER_ZERO;
      r_flash_cnt <= TIMER_ZERO;
      r_lamp      <= 1'b0;
      r_gate_cmd  <= 1'b0;
      r_closed    <= 1'b0;
`ifdef CROSSING_MOTION_TIMEOUT_EN
      r_fault     <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;

      // Shared timer restarts on every state change and saturates otherwise.
      if (w_next_state != r_state) begin
        r_timer <= TIMER_ZERO;
      end else if (r_timer != TIMER_MAX) begin
        r_timer <= r_timer + TIMER_ONE;
      end else begin
        r_timer <= r_timer;
      end

      // Lamp is dark in IDLE, starts lit on WARN entry, then free-runs.
      if (w_next_state == ST_IDLE) begin
        r_lamp      <= 1'b0;
        r_flash_cnt <= TIMER_ZERO;
      end else if (r_state == ST_IDLE) begin
        r_lamp      <= 1'b1;
        r_flash_cnt <= TIMER_ZERO;
      end else if (r_flash_cnt == FLASH_LAST) begin
        r_lamp      <= ~r_lamp;
        r_flash_cnt <= TIMER_ZERO;
      end else begin
        r_flash_cnt <= r_flash_cnt + TIMER_ONE;
      end

      r_gate_cmd <= gate_down_state(w_next_state);
      r_closed   <= (w_next_state == ST_CLOSED);
`ifdef CROSSING_MOTION_TIMEOUT_EN
      r_fault    <= (w_next_state == ST_FAULT);
`endif
    end
  end

  assign gate_cmd = r_gate_cmd;
  assign lamp     = r_lamp;
  // The rail signal additionally requires the live down-limit so it drops
  // the moment the gate leaves its down position.
  assign train_ok = r_closed & gate_down_lim;

`ifdef CROSSING_MOTION_TIMEOUT_EN
  assign fault = r_fault;
`else
  assign fault = 1'b0;
`endif

endmodule
